draw_rct_img: RTL and testbench

//  Overlays a 48x64 sprite, read from an external synchronous ROM, onto the VGA pixel stream.
//  It sits directly downstream of the rectangle position controller, which drives xpos/ypos.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/delay.sv | 25 ++
 rtl/draw_rct_img.sv | 115 +++++++++++
 tb/tb_draw_rct_img.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the rgb type and the timing bundle that travels
// with each pixel through the overlay pipeline.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned RCT_W    = 48;
  localparam int unsigned RCT_H    = 64;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned POS_W    = 12;
  localparam int unsigned ADDR_W   = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t TRANSP_KEY = 12'hF0F;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
    rgb_t             rgb;
  } vga_bus_t;

  // Saturate a position so the whole sprite stays on screen.
  function automatic logic [POS_W-1:0] clamp(input logic [POS_W-1:0] v,
                                             input logic [POS_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/delay.sv
// Generic CLK_DEL-stage register line with asynchronous active-high reset.
module delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_rct_img.sv
// Overlays a ROM-backed sprite onto the VGA stream; positions are latched once
// per frame at vblank start, and every output trails its input by 3 clocks.
module draw_rct_img
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [POS_W-1:0]  xpos,
  input  logic [POS_W-1:0]  ypos,
  input  logic [CNT_W-1:0]  hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [CNT_W-1:0]  vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [RGB_W-1:0]  rgb_pixel,
  output logic [CNT_W-1:0]  hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [CNT_W-1:0]  vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - RCT_W);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - RCT_H);
  localparam logic [POS_W-1:0] W_M1  = POS_W'(RCT_W - 1);
  localparam logic [POS_W-1:0] H_M1  = POS_W'(RCT_H - 1);

  vga_bus_t               bus_in;
  vga_bus_t               bus_d2;
  logic                   vblnk_prev;
  logic [POS_W-1:0]       x_lat;
  logic [POS_W-1:0]       y_lat;
  logic [POS_W-1:0]       h_ext;
  logic [POS_W-1:0]       v_ext;
  logic [POS_W-1:0]       dx;
  logic [POS_W-1:0]       dy;
  logic                   hit;
  logic [ADDR_W-1:0]      addr_nxt;
  logic                   inside_d1;
  logic                   inside_d2;

  assign bus_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                    rgb: rgb_in};

  // Timing and background colour ride alongside the address/ROM stages.
  delay #(
    .WIDTH   ($bits(vga_bus_t)),
    .CLK_DEL (2)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (bus_in),
    .dout (bus_d2)
  );

  // Sample positions only on the rising edge of vblank so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        x_lat <= clamp(xpos, X_MAX);
        y_lat <= clamp(ypos, Y_MAX);
      end
    end
  end

  always_comb begin
    h_ext    = POS_W'(hcount_in);
    v_ext    = POS_W'(vcount_in);
    dx       = h_ext - x_lat;
    dy       = v_ext - y_lat;
    hit      = !hblnk_in && !vblnk_in &&
               (h_ext >= x_lat) && (h_ext <= x_lat + W_M1) &&
               (v_ext >= y_lat) && (v_ext <= y_lat + H_M1);
    addr_nxt = hit ? {dy[5:0], dx[5:0]} : '0;
  end

  // S1 address, S2 ROM access, S3 composite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_addr <= '0;
      inside_d1  <= 1'b0;
      inside_d2  <= 1'b0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      pixel_addr <= addr_nxt;
      inside_d1  <= hit;
      inside_d2  <= inside_d1;
      hcount_out <= bus_d2.hcount;
      hsync_out  <= bus_d2.hsync;
      hblnk_out  <= bus_d2.hblnk;
      vcount_out <= bus_d2.vcount;
      vsync_out  <= bus_d2.vsync;
      vblnk_out  <= bus_d2.vblnk;
      rgb_out    <= (inside_d2 && (rgb_pixel != TRANSP_KEY)) ? rgb_pixel : bus_d2.rgb;
    end
  end

endmodule

// File: tb/tb_draw_rct_img.sv
// Directed scoreboard bench for draw_rct_img: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them when they fall due.
module tb_draw_rct_img;
  import vga_pkg::*;

  typedef struct {
    int       due;
    vga_bus_t exp;
  } out_e;

  typedef struct {
    int          due;
    logic [11:0] a;
  } addr_e;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          rom_mode = 0;
  out_e        out_q[$];
  addr_e       addr_q[$];

  draw_rct_img dut (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM model: address as colour, or a fixed colour.
  always @(posedge clk) begin
    case (rom_mode)
      1:       rgb_pixel <= 12'hF0F;
      2:       rgb_pixel <= 12'h0F0;
      default: rgb_pixel <= pixel_addr;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    out_e     e;
    addr_e    a;
    vga_bus_t act;
    if (!rst) begin
      act = '{hcount: hcount_out, hsync: hsync_out, hblnk: hblnk_out,
              vcount: vcount_out, vsync: vsync_out, vblnk: vblnk_out, rgb: rgb_out};
      while (out_q.size() > 0 && out_q[0].due <= cyc) begin
        e = out_q.pop_front();
        n_chk++;
        if (e.due < cyc) begin
          n_fail++;
          $display("FAIL out_stale: due %0d at cycle %0d", e.due, cyc);
        end else if (act !== e.exp) begin
          n_fail++;
          $display("FAIL outputs @%0d: got %h expected %h", cyc, act, e.exp);
        end
      end
      while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
        a = addr_q.pop_front();
        n_chk++;
        if (a.due < cyc || pixel_addr !== a.a) begin
          n_fail++;
          $display("FAIL pixel_addr @%0d: got %h expected %h", cyc, pixel_addr, a.a);
        end
      end
    end
  end

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic hs,
                     input logic hb, input logic vs, input logic vb, input logic [11:0] rgb,
                     input logic [11:0] exp_rgb, input logic [11:0] exp_addr);
    out_e  e;
    addr_e a;
    hcount_in = h; vcount_in = v; hsync_in = hs; hblnk_in = hb;
    vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
    e.due = cyc + 3;
    e.exp = '{hcount: h, hsync: hs, hblnk: hb, vcount: v, vsync: vs, vblnk: vb, rgb: exp_rgb};
    a.due = cyc + 1;
    a.a   = exp_addr;
    out_q.push_back(e);
    addr_q.push_back(a);
    @(posedge clk); #1;
  endtask

  // Active-area pixel, background 0xABC.
  task automatic px(input logic [10:0] h, input logic [10:0] v,
                    input logic [11:0] exp_rgb, input logic [11:0] exp_addr);
    pix(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, exp_rgb, exp_addr);
  endtask

  // Horizontally blanked pixel: always background, address 0.
  task automatic bg(input logic [10:0] h, input logic [10:0] v, input logic vb);
    pix(h, v, 1'b1, 1'b1, vb, vb, 12'h5A5, 12'h5A5, 12'h000);
  endtask

  // Leave vblank low for a cycle then raise it, latching current xpos/ypos.
  task automatic latch_pos;
    bg(11'd0, 11'd599, 1'b0);
    bg(11'd0, 11'd600, 1'b1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    xpos = '0; ypos = '0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0;
    vsync_in = 0; vblnk_in = 0; rgb_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Load non-zero timing, then assert reset between edges.
    hcount_in = 11'd5; vcount_in = 11'd7; hsync_in = 1; hblnk_in = 1; rgb_in = 12'h321;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_hcount", 32'(hcount_out), 32'd5);
    #3 rst = 1'b1;
    #1;
    chk("rst_hcount", 32'(hcount_out), 32'd0);
    chk("rst_vcount", 32'(vcount_out), 32'd0);
    chk("rst_sync_blnk", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    chk("rst_addr", 32'(pixel_addr), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Mid-frame release: sprite sits at (0,0).
    px(11'd3,  11'd2,  12'h083, 12'h083);
    px(11'd48, 11'd0,  12'hABC, 12'h000);
    px(11'd47, 11'd63, 12'hFEF, 12'hFEF);
    px(11'd0,  11'd64, 12'hABC, 12'h000);
    px(11'd0,  11'd0,  12'h000, 12'h000);

    // Latch (100,200); a mid-frame xpos change must be ignored.
    xpos = 12'd100; ypos = 12'd200;
    latch_pos();
    xpos = 12'd300;
    bg(11'd1, 11'd601, 1'b1);
    px(11'd99,  11'd200, 12'hABC, 12'h000);
    px(11'd100, 11'd200, 12'h000, 12'h000);
    px(11'd147, 11'd263, 12'hFEF, 12'hFEF);
    px(11'd148, 11'd263, 12'hABC, 12'h000);
    px(11'd100, 11'd264, 12'hABC, 12'h000);
    px(11'd100, 11'd199, 12'hABC, 12'h000);
    px(11'd105, 11'd210, 12'h285, 12'h285);
    pix(11'd105, 11'd210, 1'b0, 1'b1, 1'b0, 1'b0, 12'hABC, 12'hABC, 12'h000);

    // Next frame picks up xpos=300.
    latch_pos();
    px(11'd300, 11'd200, 12'h000, 12'h000);
    px(11'd347, 11'd263, 12'hFEF, 12'hFEF);
    px(11'd105, 11'd210, 12'hABC, 12'h000);

    // Transparency key lets the background through; other colours win.
    bg(11'd0, 11'd0, 1'b0);
    rom_mode = 1;
    pix(11'd305, 11'd210, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'h123, 12'h285);
    bg(11'd0, 11'd0, 1'b0);
    bg(11'd0, 11'd0, 1'b0);
    rom_mode = 2;
    pix(11'd305, 11'd210, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'h0F0, 12'h285);
    bg(11'd0, 11'd0, 1'b0);
    bg(11'd0, 11'd0, 1'b0);
    rom_mode = 0;

    // Clamp to (752,536): bottom-right corner is inside.
    xpos = 12'd900; ypos = 12'd4000;
    latch_pos();
    px(11'd799, 11'd599, 12'hFEF, 12'hFEF);
    px(11'd752, 11'd536, 12'h000, 12'h000);
    px(11'd751, 11'd599, 12'hABC, 12'h000);
    pix(11'd799, 11'd599, 1'b0, 1'b1, 1'b0, 1'b0, 12'hABC, 12'hABC, 12'h000);

    // Random blanked timing stream: every output is its input 3 clocks later.
    for (int i = 0; i < 300; i++) begin
      logic [11:0] r;
      r = 12'($urandom);
      pix(11'($urandom), 11'($urandom), 1'($urandom), 1'b1, 1'($urandom),
          1'($urandom), r, r, 12'h000);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("out_q_drained", 32'(out_q.size()), 32'd0);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
